// File: rtl/fb_scan_arbiter_if.sv
// Writer handshake and framebuffer RAM bus for fb_scan_arbiter.
// slave  : the arbiter.
// master : the writer together with the RAM.
interface fb_scan_arbiter_if #(
  parameter int ADDR_W = 17
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [11:0]       wr_data;
  logic [3:0]        wr_mask;
  logic              wr_ack;
  logic              wr_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [3:0]        mem_wmask;
  logic [11:0]       mem_wdata;
  logic [11:0]       mem_rdata;

  modport slave (
    input  wr_req, wr_addr, wr_data, wr_mask, mem_rdata,
    output wr_ack, wr_err, mem_addr, mem_we, mem_wmask, mem_wdata
  );

  modport master (
    output wr_req, wr_addr, wr_data, wr_mask, mem_rdata,
    input  wr_ack, wr_err, mem_addr, mem_we, mem_wmask, mem_wdata
  );
endinterface

// File: rtl/fb_scan_arbiter.sv
// fb_scan_arbiter: shares one single-port framebuffer RAM between VGA
// scanout (one read per 4 pixels plus a line-start prefetch in blanking)
// and a single pixel writer that gets every leftover slot.
// Optional macro FB_ARB_STATS_EN builds the saturating writer stall counter;
// without it stall_cnt is tied to zero.
module fb_scan_arbiter #(
  parameter int H_WORDS = 160,
  parameter int V_LINES = 480,
  parameter int ADDR_W  = 17
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [9:0]          scan_x,
  input  logic [9:0]          scan_y,
  input  logic                scan_active,
  output logic [2:0]          rgb,
  fb_scan_arbiter_if.slave    bus,
  output logic [15:0]         stall_cnt
);

  localparam logic [ADDR_W-1:0] FB_WORDS = ADDR_W'(H_WORDS * V_LINES);

  // Line base address; y*160 built from shifts, so H_WORDS must stay 160.
  function automatic logic [ADDR_W-1:0] line_base(input logic [9:0] y);
    logic [ADDR_W-1:0] yw;
    yw = ADDR_W'(y);
    return (yw << 7) + (yw << 5);
  endfunction

  logic              active_q;
  logic [9:0]        y_q;
  logic [9:0]        next_line;
  logic              pf_pending;
  logic              rd_q;
  logic [11:0]       current_word;
  logic [ADDR_W-1:0] addr_q;
  logic              err_q;
  logic              pf_go, sc_go, wr_go, wr_ok;
  logic [ADDR_W-1:0] sc_addr;

  // Slot owner (prefetch > scanout > writer) and the RAM bus it drives.
  always_comb begin
    pf_go   = !rst && !scan_active && pf_pending;
    sc_go   = !rst && scan_active && (scan_x[1:0] == 2'b10) && (scan_x < 10'd636);
    wr_go   = !rst && bus.wr_req && !pf_go && !sc_go;
    wr_ok   = bus.wr_addr < FB_WORDS;
    sc_addr = line_base(scan_y) + ADDR_W'(scan_x[9:2]) + ADDR_W'(1);

    bus.mem_addr  = rst ? '0 : addr_q;
    bus.mem_we    = 1'b0;
    bus.mem_wmask = 4'h0;
    bus.mem_wdata = 12'h000;
    bus.wr_ack    = 1'b0;
    if (pf_go) begin
      bus.mem_addr = line_base(next_line);
    end else if (sc_go) begin
      bus.mem_addr = sc_addr;
    end else if (wr_go) begin
      // Out-of-range writes are acked so the writer never hangs, but not stored.
      bus.mem_addr  = bus.wr_addr;
      bus.mem_we    = wr_ok;
      bus.mem_wmask = bus.wr_mask;
      bus.mem_wdata = bus.wr_data;
      bus.wr_ack    = 1'b1;
    end
  end

  // Line tracking: on the fall of scan_active, queue a prefetch of the next line.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q   <= 1'b0;
      y_q        <= '0;
      next_line  <= '0;
      pf_pending <= 1'b1;
    end else begin
      active_q <= scan_active;
      y_q      <= scan_y;
      if (active_q && !scan_active) begin
        next_line  <= (y_q == 10'(V_LINES - 1)) ? 10'd0 : y_q + 10'd1;
        pf_pending <= 1'b1;
      end else if (pf_go) begin
        pf_pending <= 1'b0;
      end
    end
  end

  // Read return capture, address hold for idle slots, sticky address error.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q         <= 1'b0;
      current_word <= '0;
      addr_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      rd_q   <= pf_go | sc_go;
      addr_q <= bus.mem_addr;
      if (rd_q)
        current_word <= bus.mem_rdata;
      if (wr_go && !wr_ok)
        err_q <= 1'b1;
    end
  end

  assign bus.wr_err = err_q;

  // Pixel select from the current word; black outside the visible area.
  always_comb begin
    rgb = 3'b000;
    if (scan_active) begin
      case (scan_x[1:0])
        2'd0: rgb = current_word[2:0];
        2'd1: rgb = current_word[5:3];
        2'd2: rgb = current_word[8:6];
        default: rgb = current_word[11:9];
      endcase
    end
  end

`ifdef FB_ARB_STATS_EN
  // Count cycles the writer waits on a request; saturates.
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (bus.wr_req && !wr_go && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fb_scan_arbiter.sv
// Directed bench for fb_scan_arbiter with a behavioural 1-cycle-latency RAM.
module tb_fb_scan_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  scan_x = '0;
  logic [9:0]  scan_y = '0;
  logic        scan_active = 1'b0;
  logic [2:0]  rgb;
  logic [15:0] stall_cnt;
  int          n_assert = 0;
  int          n_fail = 0;

`ifdef FB_ARB_STATS_EN
  localparam int EXP_STALL = 3;
`else
  localparam int EXP_STALL = 0;
`endif

  fb_scan_arbiter_if #(.ADDR_W(17)) bus ();

  fb_scan_arbiter #(.H_WORDS(160), .V_LINES(480), .ADDR_W(17)) dut (
    .clk(clk), .rst(rst), .scan_x(scan_x), .scan_y(scan_y),
    .scan_active(scan_active), .rgb(rgb), .bus(bus), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // RAM model: masked writes, registered read.
  logic [11:0] ram [0:76799];
  always @(posedge clk) begin
    if (bus.mem_we && bus.mem_addr < 17'd76800)
      for (int i = 0; i < 4; i++)
        if (bus.mem_wmask[i]) ram[bus.mem_addr][3*i +: 3] <= bus.mem_wdata[3*i +: 3];
    bus.mem_rdata <= (bus.mem_addr < 17'd76800) ? ram[bus.mem_addr] : 12'h000;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_scan(input int x, input int y, input bit act);
    scan_x = 10'(x);
    scan_y = 10'(y);
    scan_active = act;
  endtask

  // Active pixels x=0..n-1 of line y, then drops scan_active (caller is in the fall cycle).
  task automatic run_line(input int y, input int n);
    for (int x = 0; x < n; x++) begin
      set_scan(x, y, 1'b1);
      tick();
    end
    set_scan(0, 0, 1'b0);
  endtask

  task automatic write_word(input int a, input int d, input int m, input string tag);
    bit got;
    got = 1'b0;
    bus.wr_req = 1'b1; bus.wr_addr = 17'(a); bus.wr_data = 12'(d); bus.wr_mask = 4'(m);
    for (int k = 0; k < 8; k++) begin
      #2;
      if (bus.wr_ack === 1'b1) begin
        got = 1'b1;
        chk({tag, " we"}, 32'(bus.mem_we), 1);
        tick();
        break;
      end
      tick();
    end
    chk({tag, " ack"}, 32'(got), 1);
    bus.wr_req = 1'b0;
  endtask

  initial begin
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_mask = '0;
    rst = 1'b1;
    tick(); tick();
    // Request during reset is ignored; reset output values.
    bus.wr_req = 1'b1; bus.wr_addr = 17'd5; bus.wr_data = 12'hFFF; bus.wr_mask = 4'hF;
    #2;
    chk("rst ack",   32'(bus.wr_ack), 0);
    chk("rst we",    32'(bus.mem_we), 0);
    chk("rst addr",  32'(bus.mem_addr), 0);
    chk("rst wmask", 32'(bus.mem_wmask), 0);
    chk("rst err",   32'(bus.wr_err), 0);
    chk("rst stall", 32'(stall_cnt), 0);
    tick();
    rst = 1'b0; bus.wr_req = 1'b0;
    #2;
    chk("pf0 addr", 32'(bus.mem_addr), 0);
    chk("pf0 we",   32'(bus.mem_we), 0);
    chk("pf0 ack",  32'(bus.wr_ack), 0);
    tick(); repeat (3) tick();

    // Preload via the writer path during blanking.
    write_word(320, 'b111_101_011_001, 'hF, "pre320");
    write_word(321, 'b010_110_100_011, 'hF, "pre321");
    write_word(100, 0, 'hF, "pre100");

    // Line 1 ends -> prefetch of line 2 (word 320) one cycle after the fall.
    run_line(1, 2);
    #2; tick();
    #2;
    chk("pf line2 addr", 32'(bus.mem_addr), 320);
    chk("pf line2 we",   32'(bus.mem_we), 0);
    tick(); repeat (3) tick();

    // Line 2 scanout.
    set_scan(0, 2, 1'b1); #2; chk("y2 x0 rgb", 32'(rgb), 'b001); tick();
    set_scan(1, 2, 1'b1); #2; chk("y2 x1 rgb", 32'(rgb), 'b011); tick();
    set_scan(2, 2, 1'b1); #2;
    chk("y2 x2 rgb",  32'(rgb), 'b101);
    chk("y2 x2 addr", 32'(bus.mem_addr), 321);
    chk("y2 x2 we",   32'(bus.mem_we), 0);
    tick();
    set_scan(3, 2, 1'b1); #2; chk("y2 x3 rgb", 32'(rgb), 'b111); tick();
    set_scan(4, 2, 1'b1); #2; chk("y2 x4 rgb", 32'(rgb), 'b011); tick();
    set_scan(0, 0, 1'b0); #2; chk("blank rgb", 32'(rgb), 0); tick();
    repeat (3) tick();

    // Line 5: writer collides with scanout read at x=6, granted at x=7.
    for (int x = 0; x < 6; x++) begin
      set_scan(x, 5, 1'b1);
      tick();
    end
    set_scan(6, 5, 1'b1);
    bus.wr_req = 1'b1; bus.wr_addr = 17'd100; bus.wr_data = 12'hABC; bus.wr_mask = 4'b0101;
    #2;
    chk("y5 x6 ack",  32'(bus.wr_ack), 0);
    chk("y5 x6 addr", 32'(bus.mem_addr), 802);
    tick();
    set_scan(7, 5, 1'b1); #2;
    chk("y5 x7 ack",   32'(bus.wr_ack), 1);
    chk("y5 x7 we",    32'(bus.mem_we), 1);
    chk("y5 x7 addr",  32'(bus.mem_addr), 100);
    chk("y5 x7 wmask", 32'(bus.mem_wmask), 'b0101);
    chk("y5 x7 wdata", 32'(bus.mem_wdata), 'hABC);
    tick();
    bus.wr_req = 1'b0;
    set_scan(8, 5, 1'b1); #2;
    chk("y5 x8 ack", 32'(bus.wr_ack), 0);
    chk("ram100",    32'(ram[100]), 'h084);
    tick();
    set_scan(0, 0, 1'b0); tick(); repeat (4) tick();

    // Out-of-range write during blanking.
    bus.wr_req = 1'b1; bus.wr_addr = 17'd76800; bus.wr_data = 12'hFFF; bus.wr_mask = 4'hF;
    #2;
    chk("oor ack",    32'(bus.wr_ack), 1);
    chk("oor we",     32'(bus.mem_we), 0);
    chk("oor err pre", 32'(bus.wr_err), 0);
    tick();
    bus.wr_req = 1'b0; #2;
    chk("oor err set", 32'(bus.wr_err), 1);
    chk("oor ack off", 32'(bus.wr_ack), 0);
    repeat (3) tick();
    #2; chk("oor err sticky", 32'(bus.wr_err), 1);
    tick();

    // Line 479 -> prefetch wraps to line 0.
    run_line(479, 3);
    #2; chk("y479 fall hold addr", 32'(bus.mem_addr), 76641);
    tick();
    #2;
    chk("wrap pf addr", 32'(bus.mem_addr), 0);
    chk("wrap pf we",   32'(bus.mem_we), 0);
    chk("err still",    32'(bus.wr_err), 1);
    tick(); repeat (3) tick();

    // Line 10 -> prefetch of line 11.
    run_line(10, 3);
    #2; tick();
    #2; chk("y10 pf addr", 32'(bus.mem_addr), 1760);
    tick(); tick();

    // Reset clears the sticky error.
    rst = 1'b1; tick();
    rst = 1'b0; #2;
    chk("post rst err",   32'(bus.wr_err), 0);
    chk("post rst stall", 32'(stall_cnt), 0);
    tick(); repeat (2) tick();

    // Writer held through an active line: stalls only on scanout slots.
    bus.wr_req = 1'b1; bus.wr_addr = 17'd200; bus.wr_data = 12'h000; bus.wr_mask = 4'hF;
    for (int x = 0; x < 12; x++) begin
      set_scan(x, 20, 1'b1);
      #2;
      chk($sformatf("stat ack x%0d", x), 32'(bus.wr_ack), (x % 4 == 2) ? 0 : 1);
      tick();
    end
    set_scan(12, 20, 1'b1);
    bus.wr_req = 1'b0;
    #2; chk("stall_cnt", 32'(stall_cnt), EXP_STALL);
    tick();
    set_scan(0, 0, 1'b0); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
